// File: rtl/move_sched_pkg.sv
// move_sched_pkg
// Shared types and helpers for the movement scheduler.
//   sched_state_t  : scheduler FSM states (IDLE, OFFER)
//   NUM_SPEED_DEF  : default number of speed tick inputs
//   clamp_level()  : maps a raw 3-bit level onto a valid speed_pulse index
package move_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_t;

    localparam int NUM_SPEED_DEF = 6;

    function automatic logic [2:0] clamp_level(input logic [2:0] lvl, input int num_speed);
        if (int'(lvl) >= num_speed) begin
            return 3'(num_speed - 1);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/move_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker. Searches req starting one slot past
// last_grant, wrapping around, and returns the first set bit.
// Ports:
//   req        in  N            request vector
//   last_grant in  $clog2(N)    most recently granted index
//   grant      out $clog2(N)    selected index (0 when no request)
//   any_req    out 1            at least one request bit set
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_req && req[W'(idx)]) begin
                any_req = 1'b1;
                grant   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler
// Picks the speed tick selected by the difficulty level, latches one movement
// request per active object slot on every such tick, and hands the requests
// to the single position-update unit in round-robin order over a
// valid/ready handshake.
// Optional feature macro: MOVE_SCHED_MISS_CNT_EN adds a saturating counter of
// ticks that arrived while the slot's previous request was still pending.
// Ports:
//   clk100MHz    in  1                system clock
//   rst          in  1                synchronous reset, active-high
//   speed_pulse  in  NUM_SPEED        one-cycle tick pulses, one per speed
//   level        in  3                speed select (clamped to NUM_SPEED-1)
//   obj_active   in  NUM_OBJ          live object slots
//   upd_valid    out 1                update offered
//   upd_id       out $clog2(NUM_OBJ)  slot of the offered update
//   upd_ready    in  1                update unit accepts
//   busy         out 1                pending work or an offer in flight
//   miss_cnt     out MISS_W           missed ticks (MOVE_SCHED_MISS_CNT_EN only)
//
// state | meaning
// IDLE  | no offer outstanding; level_q tracks level; arbitrate pending
// OFFER | upd_valid high, upd_id frozen until the update unit accepts
module move_scheduler
    import move_sched_pkg::*;
#(
    parameter int NUM_OBJ   = 4,
    parameter int NUM_SPEED = NUM_SPEED_DEF,
    parameter int MISS_W    = 8,
    localparam int ID_W     = $clog2(NUM_OBJ)
) (
    input  logic                 clk100MHz,
    input  logic                 rst,
    input  logic [NUM_SPEED-1:0] speed_pulse,
    input  logic [2:0]           level,
    input  logic [NUM_OBJ-1:0]   obj_active,
    output logic                 upd_valid,
    output logic [ID_W-1:0]      upd_id,
    input  logic                 upd_ready,
    output logic                 busy
`ifdef MOVE_SCHED_MISS_CNT_EN
    ,
    output logic [MISS_W-1:0]    miss_cnt
`endif
);

    sched_state_t       state, state_nxt;
    logic [2:0]         level_q;
    logic [NUM_OBJ-1:0] pending, pending_nxt;
    logic [ID_W-1:0]    last_grant, last_grant_nxt;
    logic [ID_W-1:0]    upd_id_nxt;
    logic [ID_W-1:0]    grant;
    logic               any_req;
    logic               tick;
    logic               xfer;

    assign tick      = speed_pulse[level_q];
    assign upd_valid = (state == OFFER);
    assign xfer      = upd_valid & upd_ready;
    assign busy      = (|pending) | upd_valid;

    rr_arbiter #(.N(NUM_OBJ)) u_arb (
        .req        (pending),
        .last_grant (last_grant),
        .grant      (grant),
        .any_req    (any_req)
    );

    // Clears are applied first so that a tick on the same cycle wins.
    // The offered slot keeps its bit even if its object goes away, so the
    // frozen offer always has a matching pending bit to retire.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (!obj_active[i] && !(upd_valid && (upd_id == ID_W'(i)))) begin
                pending_nxt[i] = 1'b0;
            end
            if (xfer && (upd_id == ID_W'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            if (tick && obj_active[i]) begin
                pending_nxt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        upd_id_nxt     = upd_id;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (any_req) begin
                    upd_id_nxt = grant;
                    state_nxt  = OFFER;
                end
            end
            OFFER: begin
                if (xfer) begin
                    last_grant_nxt = upd_id;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            state      <= IDLE;
            upd_id     <= '0;
            last_grant <= ID_W'(NUM_OBJ - 1);
            pending    <= '0;
            level_q    <= '0;
        end else begin
            state      <= state_nxt;
            upd_id     <= upd_id_nxt;
            last_grant <= last_grant_nxt;
            pending    <= pending_nxt;
            if (state == IDLE) begin
                level_q <= clamp_level(level, NUM_SPEED);
            end
        end
    end

`ifdef MOVE_SCHED_MISS_CNT_EN
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    logic [MISS_W-1:0] miss_nxt;

    // A slot misses when a tick finds its previous request still waiting and
    // that request is not being retired in the same cycle.
    always_comb begin
        int inc;
        int sum;
        inc = 0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (tick && pending[i] && obj_active[i] &&
                !(xfer && (upd_id == ID_W'(i)))) begin
                inc = inc + 1;
            end
        end
        sum      = int'(miss_cnt) + inc;
        miss_nxt = (sum > MISS_MAX) ? MISS_W'(MISS_MAX) : MISS_W'(sum);
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            miss_cnt <= '0;
        end else begin
            miss_cnt <= miss_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;

    localparam int NOBJ = 4;
    localparam int NSPD = 6;
    localparam int MW   = 8;

    logic            clk100MHz = 1'b0;
    logic            rst = 1'b1;
    logic [NSPD-1:0] speed_pulse = '0;
    logic [2:0]      level = '0;
    logic [NOBJ-1:0] obj_active = '0;
    logic            upd_valid;
    logic [1:0]      upd_id;
    logic            upd_ready = 1'b0;
    logic            busy;
`ifdef MOVE_SCHED_MISS_CNT_EN
    logic [MW-1:0]   miss_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk100MHz = ~clk100MHz;

    move_scheduler #(.NUM_OBJ(NOBJ), .NUM_SPEED(NSPD), .MISS_W(MW)) dut (
        .clk100MHz   (clk100MHz),
        .rst         (rst),
        .speed_pulse (speed_pulse),
        .level       (level),
        .obj_active  (obj_active),
        .upd_valid   (upd_valid),
        .upd_id      (upd_id),
        .upd_ready   (upd_ready),
        .busy        (busy)
`ifdef MOVE_SCHED_MISS_CNT_EN
        ,
        .miss_cnt    (miss_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: abstract scheduler state held as plain values.
    logic [NOBJ-1:0] m_pend, n_pend;
    int              m_lvl, n_lvl;
    bit              m_valid, n_valid;
    int              m_id, n_id;
    int              m_last, n_last;
    int              m_miss, n_miss;
    bit              m_ok = 1'b0;

    always_comb begin
        bit tk;
        bit xf;
        bit found;
        int misses;
        int idx;
        tk      = speed_pulse[m_lvl];
        xf      = m_valid && upd_ready;
        found   = 1'b0;
        misses  = 0;
        idx     = 0;
        n_pend  = m_pend;
        n_valid = m_valid;
        n_id    = m_id;
        n_last  = m_last;
        n_lvl   = m_valid ? m_lvl : ((int'(level) > NSPD - 1) ? NSPD - 1 : int'(level));
        for (int i = 0; i < NOBJ; i++) begin
            if (tk && m_pend[i] && obj_active[i] && !(xf && m_id == i)) misses++;
            if (tk && obj_active[i])                    n_pend[i] = 1'b1;
            else if (xf && m_id == i)                   n_pend[i] = 1'b0;
            else if (!obj_active[i] && !(m_valid && m_id == i)) n_pend[i] = 1'b0;
        end
        n_miss = (m_miss + misses > 255) ? 255 : m_miss + misses;
        if (!m_valid) begin
            for (int k = 1; k <= NOBJ; k++) begin
                idx = (m_last + k) % NOBJ;
                if (!found && m_pend[idx]) begin
                    found = 1'b1;
                    n_id  = idx;
                end
            end
            n_valid = found;
        end else if (xf) begin
            n_valid = 1'b0;
            n_last  = m_id;
        end
    end

    always @(posedge clk100MHz) begin
        if (rst) begin
            m_pend  <= '0;
            m_lvl   <= 0;
            m_valid <= 1'b0;
            m_id    <= 0;
            m_last  <= NOBJ - 1;
            m_miss  <= 0;
            m_ok    <= 1'b1;
        end else begin
            m_pend  <= n_pend;
            m_lvl   <= n_lvl;
            m_valid <= n_valid;
            m_id    <= n_id;
            m_last  <= n_last;
            m_miss  <= n_miss;
        end
    end

    always @(negedge clk100MHz) begin
        if (m_ok) begin
            chk("upd_valid", int'(upd_valid), int'(m_valid));
            if (m_valid) chk("upd_id", int'(upd_id), m_id);
            chk("busy", int'(busy), int'((m_pend != 0) || m_valid));
`ifdef MOVE_SCHED_MISS_CNT_EN
            chk("miss_cnt", int'(miss_cnt), m_miss);
`endif
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk100MHz);
    endtask

    initial begin
        int exp_id;

        // reset
        rst = 1'b1;
        cyc(2);
        chk("rst_valid", int'(upd_valid), 0);
        chk("rst_id", int'(upd_id), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef MOVE_SCHED_MISS_CNT_EN
        chk("rst_miss", int'(miss_cnt), 0);
`endif
        rst = 1'b0;
        cyc();

        // one tick, slots 0 and 2, ready high
        obj_active = 4'b0101; level = 3'd0; upd_ready = 1'b1; speed_pulse = 6'b000001;
        cyc();
        speed_pulse = '0;
        chk("s1_busy_t1", int'(busy), 1);
        chk("s1_valid_t1", int'(upd_valid), 0);
        cyc();
        chk("s1_valid_t2", int'(upd_valid), 1);
        chk("s1_id0", int'(upd_id), 0);
        cyc();
        chk("s1_bubble", int'(upd_valid), 0);
        cyc();
        chk("s1_valid_t4", int'(upd_valid), 1);
        chk("s1_id2", int'(upd_id), 2);
        cyc();
        chk("s1_valid_end", int'(upd_valid), 0);
        chk("s1_busy_end", int'(busy), 0);

        // level clamp
        level = 3'd7;
        cyc();
        speed_pulse = 6'b011111;
        cyc();
        speed_pulse = '0;
        cyc();
        chk("s2_ignored", int'(busy), 0);
        speed_pulse = 6'b100000;
        cyc();
        speed_pulse = '0;
        chk("s2_taken", int'(busy), 1);
        cyc(6);
        chk("s2_drained", int'(busy), 0);

        // stalled offer with the offered object dropping
        upd_ready = 1'b0; obj_active = 4'b1111; speed_pulse = 6'b100000;
        cyc();
        speed_pulse = '0;
        cyc();
        exp_id = m_id;
        chk("s3_valid", int'(upd_valid), 1);
        obj_active = 4'b1111 & ~(4'b0001 << exp_id);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("s3_hold_valid", int'(upd_valid), 1);
            chk("s3_hold_id", int'(upd_id), exp_id);
        end
        upd_ready = 1'b1;
        cyc();
        chk("s3_xfer_done", int'(upd_valid), 0);
        cyc(10);

        // two ticks three cycles apart while stalled
        rst = 1'b1; upd_ready = 1'b0; level = 3'd0; obj_active = 4'b1111;
        cyc();
        rst = 1'b0; speed_pulse = 6'b000001;
        cyc();
        speed_pulse = '0;
        cyc(2);
        speed_pulse = 6'b000001;
        cyc();
        speed_pulse = '0;
        chk("s4_pending", int'(dut.pending), 15);
`ifdef MOVE_SCHED_MISS_CNT_EN
        chk("s4_miss", int'(miss_cnt), 4);
`endif

        // tick colliding with transfer of the offered slot
        rst = 1'b1;
        cyc();
        rst = 1'b0; obj_active = 4'b0001; speed_pulse = 6'b000001;
        cyc();
        speed_pulse = '0;
        cyc();
        chk("s5_offer", int'(upd_valid), 1);
        chk("s5_id", int'(upd_id), 0);
        upd_ready = 1'b1; speed_pulse = 6'b000001;
        cyc();
        upd_ready = 1'b0; speed_pulse = '0;
        chk("s5_pend_kept", int'(dut.pending), 1);
        chk("s5_bubble", int'(upd_valid), 0);
`ifdef MOVE_SCHED_MISS_CNT_EN
        chk("s5_miss", int'(miss_cnt), 0);
`endif
        cyc();
        chk("s5_reoffer", int'(upd_valid), 1);
        chk("s5_reid", int'(upd_id), 0);

        // reset in the middle of an offer
        rst = 1'b1;
        cyc();
        chk("s6_valid", int'(upd_valid), 0);
        chk("s6_pending", int'(dut.pending), 0);
`ifdef MOVE_SCHED_MISS_CNT_EN
        chk("s6_miss", int'(miss_cnt), 0);
`endif
        rst = 1'b0; obj_active = 4'b1111; speed_pulse = 6'b000001;
        cyc();
        speed_pulse = '0;
        cyc();
        chk("s6_first_valid", int'(upd_valid), 1);
        chk("s6_first_id", int'(upd_id), 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < NSPD; b++) speed_pulse[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) level = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) obj_active = 4'($urandom_range(0, 15));
            if (c < 2000) upd_ready = ($urandom_range(0, 2) != 0);
            else          upd_ready = ($urandom_range(0, 3) == 0);
            cyc();
        end
        rst = 1'b0; speed_pulse = '0; upd_ready = 1'b1;
        cyc(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
